// File: rtl/debounce_filter_pkg.sv
// Shared definitions for the switch debounce filter.
//   state_e              : debounce FSM states (low, checking high, high, checking low)
//   DefaultDebounceLimit : stable cycles for 10 ms at the 25 MHz board clock
//   DefaultSyncStages    : synchroniser depth for raw asynchronous switch inputs
package debounce_filter_pkg;

  typedef enum logic [1:0] {
    StLow   = 2'd0,
    StChkHi = 2'd1,
    StHigh  = 2'd2,
    StChkLo = 2'd3
  } state_e;

  localparam int unsigned DefaultDebounceLimit = 250000;
  localparam int unsigned DefaultSyncStages    = 2;

endpackage

// File: rtl/debounce_filter_switch_sync.sv
// Multi-flop synchroniser for one raw asynchronous switch level. Reusable for every switch input.
// Ports:
//   clk_i   : system clock
//   rst_ni  : synchronous active-low reset, clears the whole chain to 0
//   async_i : raw asynchronous level
//   sync_o  : level after SYNC_STAGES flops
module debounce_filter_switch_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_filter.sv
// Debounce filter for a bouncing mechanical switch. The raw level is synchronised, then must hold
// a new value for DEBOUNCE_LIMIT consecutive cycles before o_Switch follows it.
// Ports:
//   i_Clk     : system clock
//   i_Rst_L   : synchronous active-low reset
//   i_Switch  : raw asynchronous switch level
//   o_Switch  : debounced level, registered
//   o_Press   : one-cycle strobe on o_Switch 0->1
//   o_Release : one-cycle strobe on o_Switch 1->0
// Build option: DEBOUNCE_EDGE_PULSE_EN defined builds the press/release strobe registers;
// otherwise o_Press and o_Release are tied low.
module debounce_filter
  import debounce_filter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_LIMIT = DefaultDebounceLimit,
  parameter int unsigned SYNC_STAGES    = DefaultSyncStages
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_Switch,
  output logic o_Press,
  output logic o_Release
);

  localparam int unsigned    CntW        = $clog2(DEBOUNCE_LIMIT + 1);
  localparam logic [CntW-1:0] CntLast    = CntW'(DEBOUNCE_LIMIT - 1);
  localparam logic [CntW-1:0] CntOne     = CntW'(1);
  // With a limit of one the first agreeing sample already qualifies.
  localparam bit             SingleCycle = (DEBOUNCE_LIMIT == 1);

  logic            sync_s;
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            switch_q, switch_d;
  logic            rise, fall;

  debounce_filter_switch_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_switch_sync (
    .clk_i  (i_Clk),
    .rst_ni (i_Rst_L),
    .async_i(i_Switch),
    .sync_o (sync_s)
  );

  // State register
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_q  <= StLow;
      cnt_q    <= '0;
      switch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      switch_q <= switch_d;
    end
  end

  // Next state: cnt counts agreeing samples already seen; any disagreement restarts from zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StLow: begin
        cnt_d = '0;
        if (sync_s) begin
          if (SingleCycle) begin
            state_d = StHigh;
          end else begin
            state_d = StChkHi;
            cnt_d   = CntOne;
          end
        end
      end
      StChkHi: begin
        if (!sync_s) begin
          state_d = StLow;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StHigh;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StHigh: begin
        cnt_d = '0;
        if (!sync_s) begin
          if (SingleCycle) begin
            state_d = StLow;
          end else begin
            state_d = StChkLo;
            cnt_d   = CntOne;
          end
        end
      end
      StChkLo: begin
        if (sync_s) begin
          state_d = StHigh;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StLow;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = StLow;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: StLow/StChkHi are the "debounced low" side, StHigh/StChkLo the "debounced high" side.
  always_comb begin
    rise     = (state_q inside {StLow, StChkHi}) && (state_d == StHigh);
    fall     = (state_q inside {StHigh, StChkLo}) && (state_d == StLow);
    switch_d = switch_q;
    if (rise) begin
      switch_d = 1'b1;
    end else if (fall) begin
      switch_d = 1'b0;
    end
  end

  assign o_Switch = switch_q;

`ifdef DEBOUNCE_EDGE_PULSE_EN
  logic press_q, press_d;
  logic release_q, release_d;

  always_comb begin
    press_d   = rise;
    release_d = fall;
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign o_Press   = press_q;
  assign o_Release = release_q;
`else
  assign o_Press   = 1'b0;
  assign o_Release = 1'b0;
`endif

endmodule
